// File: rtl/modbus_frame_pkg.sv
// ---------------------------------------------------------------------------
// modbus_frame_pkg
// Shared definitions for the Modbus-RTU CRC frame controller.
//   state_e         : frame sequencer states
//   MIN_LEN_DEFAULT : shortest legal frame (address + function + 2 CRC bytes)
//   BCAST_ADDR      : Modbus broadcast slave address
//   LEN_W           : width of the frame length counter / frame_len output
// Optional build macro used by the importing top: MODBUS_ADDR_FILTER_EN
// ---------------------------------------------------------------------------
package modbus_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_RECV,
        ST_EVAL,
        ST_DONE
    } state_e;

    localparam int         MIN_LEN_DEFAULT = 4;
    localparam logic [7:0] BCAST_ADDR      = 8'h00;
    localparam int         LEN_W           = 9;

endpackage

// File: rtl/modbus_crc_frame_ctrl_gap_timer.sv
// ---------------------------------------------------------------------------
// gap_timer
// Inter-character silence timer. Cleared by every received byte, otherwise
// counts up and saturates at GAP_CLKS; gap_hit_o is high while saturated.
// Ports:
//   clk_i, rst_i (async, active-high)
//   clear_i   : restart the count (rx_valid)
//   gap_hit_o : count == GAP_CLKS
// ---------------------------------------------------------------------------
module gap_timer #(
    parameter int GAP_CLKS = 16709
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic gap_hit_o
);

    localparam int               CNT_W   = $clog2(GAP_CLKS + 1);
    localparam logic [CNT_W-1:0] GAP_VAL = CNT_W'(GAP_CLKS);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (cnt_q != GAP_VAL) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign gap_hit_o = (cnt_q == GAP_VAL);

endmodule

// File: rtl/modbus_crc_frame_ctrl.sv
// ---------------------------------------------------------------------------
// modbus_crc_frame_ctrl
// Paces received Modbus-RTU bytes into a bit-serial CRC-16 engine, detects
// frame end from inter-character silence and reports the frame verdict.
// Ports:
//   clk, rst (async, active-high)
//   rx_valid, rx_data      : byte strobe from the UART receiver
//   crc_load, crc_byte     : one-cycle load into the CRC engine
//   crc_init               : re-initialise engine (asserted while idle)
//   crc_zero               : engine residue is zero
//   frame_done             : one-cycle pulse, result outputs valid
//   frame_ok, frame_len, err_overrun, err_short, err_long : last frame result
//   busy                   : frame in progress
// Optional build macro MODBUS_ADDR_FILTER_EN adds my_addr (input) and
// err_addr (output); the first byte must then match my_addr or broadcast.
// ---------------------------------------------------------------------------
module modbus_crc_frame_ctrl
    import modbus_frame_pkg::*;
#(
    parameter int GAP_CLKS = 16709,
    parameter int CRC_CLKS = 17,
    parameter int MAX_LEN  = 256,
    parameter int MIN_LEN  = MIN_LEN_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             crc_load,
    output logic [7:0]       crc_byte,
    output logic             crc_init,
    input  logic             crc_zero,
    output logic             frame_done,
    output logic             frame_ok,
    output logic [LEN_W-1:0] frame_len,
    output logic             err_overrun,
    output logic             err_short,
    output logic             err_long,
`ifdef MODBUS_ADDR_FILTER_EN
    input  logic [7:0]       my_addr,
    output logic             err_addr,
`endif
    output logic             busy
);

    localparam int WAIT_W = $clog2(CRC_CLKS + 1);

    state_e            state_q, state_d;
    logic [7:0]        hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              ovr_q, ovr_d;
    logic              long_q, long_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [LEN_W-1:0]  res_len_q, res_len_d;
    logic              res_ok_q, res_ok_d;
    logic              res_short_q, res_short_d;
    logic              res_long_q, res_long_d;
    logic              res_ovr_q, res_ovr_d;
    logic              gap_hit;
    logic              len_room;
    logic              short_now;
    logic              addr_ok;
`ifdef MODBUS_ADDR_FILTER_EN
    logic [7:0]        addr_q, addr_d;
    logic              res_addr_q, res_addr_d;
`endif

    gap_timer #(
        .GAP_CLKS (GAP_CLKS)
    ) u_gap_timer (
        .clk_i     (clk),
        .rst_i     (rst),
        .clear_i   (rx_valid),
        .gap_hit_o (gap_hit)
    );

    assign len_room  = (len_q < LEN_W'(MAX_LEN));
    assign short_now = (len_q < LEN_W'(MIN_LEN));
`ifdef MODBUS_ADDR_FILTER_EN
    assign addr_ok   = (addr_q == my_addr) || (addr_q == BCAST_ADDR);
`else
    assign addr_ok   = 1'b1;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (hold_full_q) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_WAIT;
            ST_WAIT: if (wait_q == WAIT_W'(CRC_CLKS - 1)) state_d = ST_RECV;
            ST_RECV: begin
                // A byte landing on the gap_hit cycle keeps the frame open.
                if (hold_full_q) begin
                    state_d = ST_LOAD;
                end else if (gap_hit && !rx_valid) begin
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        crc_init   = (state_q == ST_IDLE);
        crc_load   = (state_q == ST_LOAD) && len_room;
        frame_done = (state_q == ST_DONE);
        busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    end

    // Holding register, frame counters and result capture
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        len_d       = len_q;
        ovr_d       = ovr_q;
        long_d      = long_q;
        wait_d      = wait_q;
        res_len_d   = res_len_q;
        res_ok_d    = res_ok_q;
        res_short_d = res_short_q;
        res_long_d  = res_long_q;
        res_ovr_d   = res_ovr_q;
`ifdef MODBUS_ADDR_FILTER_EN
        addr_d      = addr_q;
        res_addr_d  = res_addr_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    len_d  = '0;
                    ovr_d  = 1'b0;
                    long_d = 1'b0;
                end
            end
            ST_LOAD: begin
                hold_full_d = 1'b0;
                wait_d      = '0;
                if (len_room) begin
                    len_d = len_q + LEN_W'(1);
                end else begin
                    long_d = 1'b1;
                end
`ifdef MODBUS_ADDR_FILTER_EN
                if (len_q == '0) addr_d = hold_q;
`endif
            end
            ST_WAIT: wait_d = wait_q + WAIT_W'(1);
            ST_EVAL: begin
                res_len_d   = len_q;
                res_short_d = short_now;
                res_long_d  = long_q;
                res_ovr_d   = ovr_q;
                res_ok_d    = crc_zero && !short_now && !long_q && !ovr_q && addr_ok;
`ifdef MODBUS_ADDR_FILTER_EN
                res_addr_d  = !addr_ok;
`endif
            end
            default: ;
        endcase
        // Applied after the IDLE clear so a drop on the frame's first cycle sticks.
        if (rx_valid) begin
            if (hold_full_q) begin
                ovr_d = 1'b1;
            end else begin
                hold_d      = rx_data;
                hold_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            len_q       <= '0;
            ovr_q       <= 1'b0;
            long_q      <= 1'b0;
            wait_q      <= '0;
            res_len_q   <= '0;
            res_ok_q    <= 1'b0;
            res_short_q <= 1'b0;
            res_long_q  <= 1'b0;
            res_ovr_q   <= 1'b0;
`ifdef MODBUS_ADDR_FILTER_EN
            addr_q      <= '0;
            res_addr_q  <= 1'b0;
`endif
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            len_q       <= len_d;
            ovr_q       <= ovr_d;
            long_q      <= long_d;
            wait_q      <= wait_d;
            res_len_q   <= res_len_d;
            res_ok_q    <= res_ok_d;
            res_short_q <= res_short_d;
            res_long_q  <= res_long_d;
            res_ovr_q   <= res_ovr_d;
`ifdef MODBUS_ADDR_FILTER_EN
            addr_q      <= addr_d;
            res_addr_q  <= res_addr_d;
`endif
        end
    end

    assign crc_byte    = hold_q;
    assign frame_len   = res_len_q;
    assign frame_ok    = res_ok_q;
    assign err_short   = res_short_q;
    assign err_long    = res_long_q;
    assign err_overrun = res_ovr_q;
`ifdef MODBUS_ADDR_FILTER_EN
    assign err_addr    = res_addr_q;
`endif

endmodule

// File: tb/tb_modbus_crc_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_modbus_crc_frame_ctrl
// Self-checking bench: a behavioural CRC engine stub drives crc_zero, and a
// frame-level reference model predicts each frame's result from the list of
// accepted bytes (CRC of the payload compared with the two trailing bytes).
// Timing is scaled down: GAP_CLKS=200, MAX_LEN=16, character spacing 52.
// ---------------------------------------------------------------------------
module tb_modbus_crc_frame_ctrl;

    localparam int GAP  = 200;
    localparam int CRCC = 17;
    localparam int MAXL = 16;
    localparam int MINL = 4;
    localparam int SP   = 52;

    typedef logic [7:0] bq_t[$];

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data  = 8'h00;
    logic       crc_load;
    logic [7:0] crc_byte;
    logic       crc_init;
    logic       crc_zero;
    logic       frame_done;
    logic       frame_ok;
    logic [8:0] frame_len;
    logic       err_overrun;
    logic       err_short;
    logic       err_long;
    logic       busy;
`ifdef MODBUS_ADDR_FILTER_EN
    logic       err_addr;
`endif

    int n_cmp    = 0;
    int n_bad    = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    modbus_crc_frame_ctrl #(
        .GAP_CLKS (GAP),
        .CRC_CLKS (CRCC),
        .MAX_LEN  (MAXL),
        .MIN_LEN  (MINL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .crc_load    (crc_load),
        .crc_byte    (crc_byte),
        .crc_init    (crc_init),
        .crc_zero    (crc_zero),
        .frame_done  (frame_done),
        .frame_ok    (frame_ok),
        .frame_len   (frame_len),
        .err_overrun (err_overrun),
        .err_short   (err_short),
        .err_long    (err_long),
`ifdef MODBUS_ADDR_FILTER_EN
        .my_addr     (8'h01),
        .err_addr    (err_addr),
`endif
        .busy        (busy)
    );

    function automatic logic [15:0] crc_step(logic [15:0] c, logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    // CRC engine stub: update on load, busy for 16 clocks, init honoured when idle.
    logic [15:0] eng_crc  = 16'hFFFF;
    int          eng_busy = 0;
    always @(posedge clk) begin
        if (crc_load) begin
            eng_crc  <= crc_step(eng_crc, crc_byte);
            eng_busy <= 16;
        end else if (eng_busy > 0) begin
            eng_busy <= eng_busy - 1;
        end else if (crc_init) begin
            eng_crc <= 16'hFFFF;
        end
    end
    assign crc_zero = (eng_crc == 16'h0000) && (eng_busy == 0);

    always @(posedge clk) if (frame_done) done_cnt <= done_cnt + 1;

    // Reference: {frame_ok, frame_len, err_short, err_long, err_overrun}
    function automatic logic [12:0] ref_result(bq_t acc, bit ovr);
        int          n;
        int          ln;
        bit          lng, sh, good, ok;
        logic [15:0] c;
        n    = acc.size();
        lng  = (n > MAXL);
        ln   = lng ? MAXL : n;
        sh   = (ln < MINL);
        good = 1'b0;
        if (n >= 2) begin
            c = 16'hFFFF;
            for (int i = 0; i < n - 2; i++) c = crc_step(c, acc[i]);
            good = (c == {acc[n-1], acc[n-2]});
        end
        ok = good && !sh && !lng && !ovr;
`ifdef MODBUS_ADDR_FILTER_EN
        if (n >= 1) ok = ok && (acc[0] == 8'h01 || acc[0] == 8'h00);
`endif
        return {ok, 9'(ln), sh, lng, ovr};
    endfunction

    function automatic logic [12:0] dut_res();
        return {frame_ok, frame_len, err_short, err_long, err_overrun};
    endfunction

    function automatic bq_t make_frame(int npay, bit good);
        bq_t         q;
        logic [15:0] c;
        int          idx;
        c = 16'hFFFF;
        for (int i = 0; i < npay; i++) begin
            q.push_back(8'($urandom_range(0, 255)));
            c = crc_step(c, q[i]);
        end
        q.push_back(c[7:0]);
        q.push_back(c[15:8]);
        if (!good) begin
            idx    = $urandom_range(0, q.size() - 1);
            q[idx] = q[idx] ^ 8'($urandom_range(1, 255));
        end
        return q;
    endfunction

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(bq_t q, int sp);
        foreach (q[i]) begin
            if (i > 0) tick(sp);
            send_byte(q[i]);
        end
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int i = 0; i < GAP + 400; i++) begin
            if (frame_done) begin
                got = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    bq_t good_vec = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};

    task automatic test_reset();
        logic [24:0] obs, exp;
        rst = 1'b1;
        tick(3);
        exp = {1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        obs = {crc_load, crc_byte, crc_init, frame_done, frame_ok, frame_len,
               err_overrun, err_short, err_long, busy};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL reset_outputs got=%h expected=%h", obs, exp);
        end
        rst = 1'b0;
        tick(2);
        n_cmp++;
        if ({crc_init, busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL post_reset_idle got=%b expected=10", {crc_init, busy});
        end
    endtask

    task automatic test_crc_frames();
        bq_t         q;
        bit          got;
        int          d0;
        logic [12:0] exp;
        for (int v = 0; v < 2; v++) begin
            q = good_vec;
            if (v == 1) q[7] = 8'h0B;
            d0 = done_cnt;
            send_frame(q, SP);
            tick(3);
            n_cmp++;
            if (busy !== 1'b1) begin
                n_bad++;
                $display("FAIL crc_frame%0d_busy got=%b expected=1", v, busy);
            end
            wait_done(got);
            n_cmp++;
            if (!got) begin
                n_bad++;
                $display("FAIL crc_frame%0d_timeout got=no_done expected=done", v);
            end else begin
                exp = ref_result(q, 1'b0);
                n_cmp++;
                if (dut_res() !== exp) begin
                    n_bad++;
                    $display("FAIL crc_frame%0d_result got=%h expected=%h", v, dut_res(), exp);
                end
            end
            tick(5);
            n_cmp++;
            if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL crc_frame%0d_done_count got=%0d/busy=%b expected=1/0", v, done_cnt - d0, busy);
            end
        end
    endtask

    task automatic test_short();
        bq_t         q = '{8'h01, 8'h03};
        bit          got;
        logic [12:0] exp;
        send_frame(q, SP);
        wait_done(got);
        exp = ref_result(q, 1'b0);
        n_cmp++;
        if (!got || dut_res() !== exp) begin
            n_bad++;
            $display("FAIL short_frame got=%h done=%b expected=%h", dut_res(), got, exp);
        end
        tick(5);
    endtask

    task automatic test_overrun();
        bit          got;
        logic [12:0] exp;
        send_byte(8'h01);
        tick(3);
        send_byte(8'h03);
        tick(4);
        send_byte(8'h55);
        for (int i = 2; i < 8; i++) begin
            tick(SP);
            send_byte(good_vec[i]);
        end
        wait_done(got);
        exp = ref_result(good_vec, 1'b1);
        n_cmp++;
        if (!got || dut_res() !== exp) begin
            n_bad++;
            $display("FAIL overrun got=%h done=%b expected=%h", dut_res(), got, exp);
        end
        tick(5);
    endtask

    task automatic test_gap_coincident();
        bit          got;
        int          d0;
        logic [12:0] exp;
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick(SP);
            send_byte(good_vec[i]);
        end
        tick(GAP);
        send_byte(good_vec[3]);
        tick(5);
        n_cmp++;
        if (done_cnt !== d0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL gap_coincident_continue got=done%0d/busy%b expected=0/1", done_cnt - d0, busy);
        end
        for (int i = 4; i < 8; i++) begin
            tick(SP);
            send_byte(good_vec[i]);
        end
        wait_done(got);
        exp = ref_result(good_vec, 1'b0);
        n_cmp++;
        if (!got || dut_res() !== exp) begin
            n_bad++;
            $display("FAIL gap_coincident_result got=%h done=%b expected=%h", dut_res(), got, exp);
        end
        tick(5);
    endtask

    task automatic test_reset_mid_frame();
        bit          got;
        int          d0;
        logic [12:0] exp;
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick(SP);
            send_byte(good_vec[i]);
        end
        tick(5);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        n_cmp++;
        if ({crc_init, busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_mid_release got=%b expected=10", {crc_init, busy});
        end
        tick(GAP + 50);
        n_cmp++;
        if (done_cnt !== d0) begin
            n_bad++;
            $display("FAIL reset_mid_no_done got=%0d expected=0", done_cnt - d0);
        end
        send_frame(good_vec, SP);
        wait_done(got);
        exp = ref_result(good_vec, 1'b0);
        n_cmp++;
        if (!got || dut_res() !== exp) begin
            n_bad++;
            $display("FAIL reset_mid_next_frame got=%h done=%b expected=%h", dut_res(), got, exp);
        end
        tick(5);
    endtask

    task automatic test_long();
        bq_t         q;
        bit          got;
        logic [12:0] exp;
        q = make_frame(18, 1'b1);
        send_frame(q, 30);
        wait_done(got);
        exp = ref_result(q, 1'b0);
        n_cmp++;
        if (!got || dut_res() !== exp) begin
            n_bad++;
            $display("FAIL long_frame got=%h done=%b expected=%h", dut_res(), got, exp);
        end
        tick(5);
    endtask

    task automatic test_random();
        bq_t         q;
        bit          got;
        logic [12:0] exp;
        for (int k = 0; k < 6; k++) begin
            q = make_frame($urandom_range(0, 10), k[0] == 1'b0);
            send_frame(q, $urandom_range(25, 60));
            wait_done(got);
            exp = ref_result(q, 1'b0);
            n_cmp++;
            if (!got || dut_res() !== exp) begin
                n_bad++;
                $display("FAIL random%0d got=%h done=%b expected=%h", k, dut_res(), got, exp);
            end
            tick($urandom_range(3, 20));
        end
    endtask

    task automatic test_back_to_back();
        bq_t         qa, qb;
        bit          got;
        logic [12:0] exp;
        qa = make_frame(3, 1'b1);
        qb = make_frame($urandom_range(2, 8), 1'b1);
        send_frame(qa, 40);
        wait_done(got);
        exp = ref_result(qa, 1'b0);
        n_cmp++;
        if (!got || dut_res() !== exp) begin
            n_bad++;
            $display("FAIL b2b_first got=%h done=%b expected=%h", dut_res(), got, exp);
        end
        // First byte of the next frame arrives in the DONE cycle.
        send_frame(qb, 40);
        wait_done(got);
        exp = ref_result(qb, 1'b0);
        n_cmp++;
        if (!got || dut_res() !== exp) begin
            n_bad++;
            $display("FAIL b2b_second got=%h done=%b expected=%h", dut_res(), got, exp);
        end
        tick(5);
    endtask

    initial begin
        test_reset();
        test_crc_frames();
        test_short();
        test_overrun();
        test_gap_coincident();
        test_reset_mid_frame();
        test_long();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
